// File: rtl/uga_dyna_status_rx.sv
// Dynamixel status-packet receiver: hunts FF FF, parses ID/LEN/ERR/params, checks CHK.
// Optional inter-byte timeout is built when DYNA_RX_TIMEOUT_EN is defined.
module uga_dyna_status_rx #(
    parameter int MAX_PARAM   = 6,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                   clk_fpga,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_data_ready,
    input  logic                   bus_rx_en,
    input  logic [7:0]             expected_id,
    output logic                   busy,
    output logic                   sts_valid,
    output logic [7:0]             sts_id,
    output logic [7:0]             sts_error,
    output logic [2:0]             sts_nparam,
    output logic [8*MAX_PARAM-1:0] sts_param,
    output logic                   chk_err,
    output logic                   frame_err,
    output logic                   timeout
);

    typedef enum logic [2:0] {
        S_HUNT  = 3'd0,
        S_HDR2  = 3'd1,
        S_ID    = 3'd2,
        S_LEN   = 3'd3,
        S_ERR   = 3'd4,
        S_PARAM = 3'd5,
        S_CHK   = 3'd6
    } state_t;

    localparam logic [7:0] LEN_MAX = 8'(MAX_PARAM + 2);

    state_t                 state_q, state_d;
    logic [7:0]             id_q, id_d, len_q, len_d, err_q, err_d, sum_q, sum_d;
    logic [2:0]             idx_q, idx_d;
    logic [8*MAX_PARAM-1:0] pbuf_q, pbuf_d;
    logic                   sts_valid_q, sts_valid_d, chk_err_q, chk_err_d;
    logic                   frame_err_q, frame_err_d;
    logic [7:0]             sts_id_q, sts_id_d, sts_error_q, sts_error_d;
    logic [2:0]             sts_nparam_q, sts_nparam_d;
    logic [8*MAX_PARAM-1:0] sts_param_q, sts_param_d;
    logic                   accept_s, id_ok_s, expire_s;

    // Echo bytes (bus in TX direction) never reach the parser.
    assign accept_s = rx_data_ready & bus_rx_en;
    assign id_ok_s  = (expected_id == 8'hFE) || (expected_id == id_q);
    assign busy     = (state_q != S_HUNT);

`ifdef DYNA_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign expire_s = busy && !accept_s && (cnt_q == TW'(TIMEOUT_CYC - 1));
    assign timeout  = timeout_q;

    // Inter-byte counter: cleared by accepted bytes and while hunting.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_s || !busy || expire_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Counter and timeout pulse registers.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign expire_s = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Parser next-state, field capture and result pulses.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        len_d        = len_q;
        err_d        = err_q;
        sum_d        = sum_q;
        idx_d        = idx_q;
        pbuf_d       = pbuf_q;
        sts_valid_d  = 1'b0;
        chk_err_d    = 1'b0;
        frame_err_d  = 1'b0;
        sts_id_d     = sts_id_q;
        sts_error_d  = sts_error_q;
        sts_nparam_d = sts_nparam_q;
        sts_param_d  = sts_param_q;
`ifdef DYNA_RX_TIMEOUT_EN
        timeout_d    = 1'b0;
`endif
        if (busy && !bus_rx_en) begin
            state_d = S_HUNT;
        end else if (accept_s) begin
            case (state_q)
                S_HUNT: begin
                    state_d = (rx_data == 8'hFF) ? S_HDR2 : S_HUNT;
                end
                S_HDR2: begin
                    state_d = (rx_data == 8'hFF) ? S_ID : S_HUNT;
                end
                S_ID: begin
                    if (rx_data == 8'hFF) begin
                        state_d = S_ID;
                    end else begin
                        id_d    = rx_data;
                        sum_d   = rx_data;
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if ((rx_data < 8'd2) || (rx_data > LEN_MAX)) begin
                        frame_err_d = 1'b1;
                        state_d     = S_HUNT;
                    end else begin
                        len_d   = rx_data;
                        sum_d   = sum_q + rx_data;
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    err_d   = rx_data;
                    sum_d   = sum_q + rx_data;
                    idx_d   = 3'd0;
                    pbuf_d  = '0;
                    state_d = (len_q > 8'd2) ? S_PARAM : S_CHK;
                end
                S_PARAM: begin
                    for (int k = 0; k < MAX_PARAM; k++) begin
                        pbuf_d[8*k +: 8] = (idx_q == 3'(k)) ? rx_data : pbuf_q[8*k +: 8];
                    end
                    sum_d   = sum_q + rx_data;
                    idx_d   = idx_q + 3'd1;
                    state_d = ({5'd0, idx_q} == (len_q - 8'd3)) ? S_CHK : S_PARAM;
                end
                S_CHK: begin
                    if (rx_data != ~sum_q) begin
                        chk_err_d = 1'b1;
                    end else if (id_ok_s) begin
                        sts_valid_d  = 1'b1;
                        sts_id_d     = id_q;
                        sts_error_d  = err_q;
                        sts_nparam_d = 3'(len_q - 8'd2);
                        sts_param_d  = pbuf_q;
                    end else begin
                        sts_valid_d = 1'b0;
                    end
                    state_d = S_HUNT;
                end
                default: begin
                    state_d = S_HUNT;
                end
            endcase
        end else if (expire_s) begin
            state_d = S_HUNT;
`ifdef DYNA_RX_TIMEOUT_EN
            timeout_d = 1'b1;
`endif
        end else begin
            state_d = state_q;
        end
    end

    // State, working fields and registered outputs.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HUNT;
            id_q         <= 8'd0;
            len_q        <= 8'd0;
            err_q        <= 8'd0;
            sum_q        <= 8'd0;
            idx_q        <= 3'd0;
            pbuf_q       <= '0;
            sts_valid_q  <= 1'b0;
            chk_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            sts_id_q     <= 8'd0;
            sts_error_q  <= 8'd0;
            sts_nparam_q <= 3'd0;
            sts_param_q  <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            len_q        <= len_d;
            err_q        <= err_d;
            sum_q        <= sum_d;
            idx_q        <= idx_d;
            pbuf_q       <= pbuf_d;
            sts_valid_q  <= sts_valid_d;
            chk_err_q    <= chk_err_d;
            frame_err_q  <= frame_err_d;
            sts_id_q     <= sts_id_d;
            sts_error_q  <= sts_error_d;
            sts_nparam_q <= sts_nparam_d;
            sts_param_q  <= sts_param_d;
        end
    end

    assign sts_valid  = sts_valid_q;
    assign chk_err    = chk_err_q;
    assign frame_err  = frame_err_q;
    assign sts_id     = sts_id_q;
    assign sts_error  = sts_error_q;
    assign sts_nparam = sts_nparam_q;
    assign sts_param  = sts_param_q;

endmodule

// File: tb/tb_uga_dyna_status_rx.sv
// Bench for uga_dyna_status_rx: frame-level model drives per-cycle expectations.
// Timeout section follows DYNA_RX_TIMEOUT_EN.
module tb_uga_dyna_status_rx;

    localparam int MP = 6;
    localparam int TO = 100;
    localparam int EV_NONE = 0, EV_VALID = 1, EV_CHK = 2, EV_FERR = 3, EV_TO = 4;

    logic            clk_fpga = 1'b0;
    logic            rst_n;
    logic [7:0]      rx_data;
    logic            rx_data_ready;
    logic            bus_rx_en;
    logic [7:0]      expected_id;
    logic            busy, sts_valid, chk_err, frame_err, timeout;
    logic [7:0]      sts_id, sts_error;
    logic [2:0]      sts_nparam;
    logic [8*MP-1:0] sts_param;

    int              checks = 0;
    int              failures = 0;
    int              exp_ev = EV_NONE;
    logic [7:0]      exp_id = 8'd0, exp_err = 8'd0;
    logic [2:0]      exp_np = 3'd0;
    logic [8*MP-1:0] exp_p = '0;
    logic [7:0]      m_id, m_err;
    logic [2:0]      m_np;
    logic [8*MP-1:0] m_p;
    logic [7:0]      fr[$];

    always #5 clk_fpga = ~clk_fpga;

    uga_dyna_status_rx #(.MAX_PARAM(MP), .TIMEOUT_CYC(TO)) dut (
        .clk_fpga(clk_fpga), .rst_n(rst_n), .rx_data(rx_data),
        .rx_data_ready(rx_data_ready), .bus_rx_en(bus_rx_en),
        .expected_id(expected_id), .busy(busy), .sts_valid(sts_valid),
        .sts_id(sts_id), .sts_error(sts_error), .sts_nparam(sts_nparam),
        .sts_param(sts_param), .chk_err(chk_err), .frame_err(frame_err),
        .timeout(timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model state, just after each clock edge.
    always @(posedge clk_fpga) begin
        #1;
        check("sts_valid", 64'(sts_valid), 64'(exp_ev == EV_VALID));
        check("chk_err", 64'(chk_err), 64'(exp_ev == EV_CHK));
        check("frame_err", 64'(frame_err), 64'(exp_ev == EV_FERR));
        check("timeout", 64'(timeout), 64'(exp_ev == EV_TO));
        check("sts_id", 64'(sts_id), 64'(exp_id));
        check("sts_error", 64'(sts_error), 64'(exp_err));
        check("sts_nparam", 64'(sts_nparam), 64'(exp_np));
        check("sts_param", 64'(sts_param), 64'(exp_p));
    end

    // Frame-level rules: header FFs, LEN range, wrapping checksum, ID filter.
    task automatic model(input logic [7:0] f[$], input logic [7:0] eid,
                         output int ev, output int dec);
        int i;
        logic [7:0] len, sum;
        i = 0;
        while (i < f.size() && f[i] == 8'hFF) i++;
        m_id = f[i];
        len  = f[i+1];
        if (len < 8'd2 || len > 8'(MP + 2)) begin
            ev = EV_FERR; dec = i + 1;
            return;
        end
        m_err = f[i+2];
        m_np  = 3'(len - 8'd2);
        m_p   = '0;
        sum   = m_id + len + m_err;
        for (int k = 0; k < int'(len) - 2; k++) begin
            m_p[8*k +: 8] = f[i+3+k];
            sum = sum + f[i+3+k];
        end
        dec = i + int'(len) + 1;
        if (f[dec] != ~sum) ev = EV_CHK;
        else if (eid == 8'hFE || eid == m_id) ev = EV_VALID;
        else ev = EV_NONE;
    endtask

    task automatic drive(input logic [7:0] d, input logic rdy, input logic en, input int ev);
        @(negedge clk_fpga);
        rx_data = d; rx_data_ready = rdy; bus_rx_en = en; exp_ev = ev;
        if (ev == EV_VALID) begin
            exp_id = m_id; exp_err = m_err; exp_np = m_np; exp_p = m_p;
        end
    endtask

    task automatic idle();
        drive(8'h00, 1'b0, 1'b1, EV_NONE);
    endtask

    task automatic send_frame(input logic [7:0] f[$], input logic [7:0] eid);
        int ev, dec;
        expected_id = eid;
        model(f, eid, ev, dec);
        for (int i = 0; i < f.size() && i <= dec; i++)
            drive(f[i], 1'b1, 1'b1, (i == dec) ? ev : EV_NONE);
        idle();
    endtask

    task automatic send_raw(input logic [7:0] f[$], input logic en);
        for (int i = 0; i < f.size(); i++) drive(f[i], 1'b1, en, EV_NONE);
        idle();
    endtask

    initial begin
        rst_n = 1'b0; rx_data = 8'd0; rx_data_ready = 1'b0; bus_rx_en = 1'b1;
        expected_id = 8'h02;
        repeat (3) @(negedge clk_fpga);
        check("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        idle();

        // Ping reply
        fr = {8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFB};
        send_frame(fr, 8'h02);
        check("ping_id", 64'(sts_id), 64'h02);
        check("ping_param", 64'(sts_param), 64'h0);

        // Read-position reply
        fr = {8'hFF, 8'hFF, 8'h02, 8'h04, 8'h00, 8'h00, 8'h08, 8'hF1};
        send_frame(fr, 8'h02);
        check("rd_param", 64'(sts_param[15:0]), 64'h0800);
        check("rd_nparam", 64'(sts_nparam), 64'd2);
        check("rd_busy_low", 64'(busy), 64'd0);

        // Bad checksum, then wildcard ID
        fr = {8'hFF, 8'hFF, 8'h02, 8'h04, 8'h00, 8'h00, 8'h08, 8'hF0};
        send_frame(fr, 8'h02);
        check("bad_chk_hold", 64'(sts_param[15:0]), 64'h0800);
        fr = {8'hFF, 8'hFF, 8'h05, 8'h02, 8'h00, 8'hF8};
        send_frame(fr, 8'hFE);
        check("any_id", 64'(sts_id), 64'h05);

        // Echo ignored
        fr = {8'hFF, 8'hFF, 8'h02, 8'h05, 8'h03, 8'h1E, 8'h00, 8'h07, 8'hD2};
        send_raw(fr, 1'b0);
        check("echo_busy", 64'(busy), 64'd0);

        // Garbage then frame with an extra header byte
        fr = {8'h55, 8'hFF, 8'h12};
        send_raw(fr, 1'b1);
        fr = {8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFB};
        send_frame(fr, 8'h02);

        // Illegal LEN on both sides, then ID filter
        fr = {8'hFF, 8'hFF, 8'h02, 8'h09};
        send_frame(fr, 8'h02);
        check("len9_busy", 64'(busy), 64'd0);
        fr = {8'hFF, 8'hFF, 8'h01, 8'h01};
        send_frame(fr, 8'h02);
        fr = {8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFB};
        send_frame(fr, 8'h03);
        check("filtered_id", 64'(sts_id), 64'h02);

        // Maximum parameter count, then a short frame clears upper bytes
        fr = {8'hFF, 8'hFF, 8'h01, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h91};
        send_frame(fr, 8'hFE);
        check("max_param", 64'(sts_param), 64'h665544332211);
        fr = {8'hFF, 8'hFF, 8'h01, 8'h03, 8'h00, 8'hAA, 8'h51};
        send_frame(fr, 8'h01);
        check("one_param", 64'(sts_param), 64'h0000000000AA);

        // bus_rx_en drop mid-frame discards the partial frame
        drive(8'hFF, 1'b1, 1'b1, EV_NONE);
        drive(8'hFF, 1'b1, 1'b1, EV_NONE);
        drive(8'h02, 1'b1, 1'b1, EV_NONE);
        drive(8'h00, 1'b0, 1'b0, EV_NONE);
        fr = {8'h02, 8'h00, 8'hFB};
        send_raw(fr, 1'b1);
        check("abort_busy", 64'(busy), 64'd0);

        // Reset mid-frame
        drive(8'hFF, 1'b1, 1'b1, EV_NONE);
        drive(8'hFF, 1'b1, 1'b1, EV_NONE);
        @(negedge clk_fpga);
        rst_n = 1'b0; rx_data_ready = 1'b0; exp_ev = EV_NONE;
        exp_id = 8'd0; exp_err = 8'd0; exp_np = 3'd0; exp_p = '0;
        @(negedge clk_fpga);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        idle();

        // Inter-byte timeout
        drive(8'hFF, 1'b1, 1'b1, EV_NONE);
        drive(8'hFF, 1'b1, 1'b1, EV_NONE);
        check("busy_rise", 64'(busy), 64'd1);
        drive(8'h02, 1'b1, 1'b1, EV_NONE);
`ifdef DYNA_RX_TIMEOUT_EN
        for (int k = 1; k < TO; k++) idle();
        drive(8'h00, 1'b0, 1'b1, EV_TO);
        idle();
        check("to_busy", 64'(busy), 64'd0);
`else
        for (int k = 0; k < TO + 20; k++) idle();
        check("no_to_busy", 64'(busy), 64'd1);
        drive(8'h00, 1'b0, 1'b0, EV_NONE);
        idle();
        check("no_to_abort", 64'(busy), 64'd0);
`endif
        idle();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
